gaussian_result_joiner: RTL

- Sits directly downstream of crop_plus_gaussian.
- Joins its five independent per-frame AXI-Stream result channels (cnn_output_0..4) with the crop coordinates used for that frame.
- Converts the crop-relative Gaussian centroid into full-image coordinates.
- Re-emits one five-word packet per frame on a single AXI-Stream output with TLAST, plus a done pulse and a frame counter.

---
 rtl/gaussian_result_joiner.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/gaussian_result_joiner.sv
// gaussian_result_joiner
//   Joins the five per-frame Gaussian fit results (amplitude, mu_x, mu_y,
//   sigma_x, sigma_y) with the crop origin used for that frame, converts the
//   crop-relative centroid to full-image coordinates (saturating), and
//   re-emits one five-word AXI-Stream packet per frame.
//
// Ports
//   ap_clk, ap_rst                      clock, synchronous active-high reset
//   cnn_output_{0..4}_TDATA/TVALID/TREADY  result words (slave streams)
//   crop_X1_*, crop_Y1_*                crop origin column/row (slave streams)
//   result_TDATA/TVALID/TREADY/TLAST    packet output (master stream)
//   frame_done                          one-cycle pulse per completed packet
//   frame_count                         completed packets since reset (wraps)
module gaussian_result_joiner #(
  parameter int PIXEL_BIT_WIDTH    = 16,
  parameter int FP_FRAC            = 0,
  parameter int IMG_COL_BITWIDTH   = 10,
  parameter int IMG_ROW_BITWIDTH   = 10,
  parameter int FRAME_CNT_BITWIDTH = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [PIXEL_BIT_WIDTH-1:0]    cnn_output_0_TDATA,
  input  logic                          cnn_output_0_TVALID,
  output logic                          cnn_output_0_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]    cnn_output_1_TDATA,
  input  logic                          cnn_output_1_TVALID,
  output logic                          cnn_output_1_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]    cnn_output_2_TDATA,
  input  logic                          cnn_output_2_TVALID,
  output logic                          cnn_output_2_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]    cnn_output_3_TDATA,
  input  logic                          cnn_output_3_TVALID,
  output logic                          cnn_output_3_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]    cnn_output_4_TDATA,
  input  logic                          cnn_output_4_TVALID,
  output logic                          cnn_output_4_TREADY,
  input  logic [IMG_COL_BITWIDTH-1:0]   crop_X1_TDATA,
  input  logic                          crop_X1_TVALID,
  output logic                          crop_X1_TREADY,
  input  logic [IMG_ROW_BITWIDTH-1:0]   crop_Y1_TDATA,
  input  logic                          crop_Y1_TVALID,
  output logic                          crop_Y1_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]    result_TDATA,
  output logic                          result_TVALID,
  input  logic                          result_TREADY,
  output logic                          result_TLAST,
  output logic                          frame_done,
  output logic [FRAME_CNT_BITWIDTH-1:0] frame_count
);

  localparam int W  = PIXEL_BIT_WIDTH;
  localparam int SW = PIXEL_BIT_WIDTH + 2;
  localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_COLLECT, S_COMPUTE, S_EMIT} state_e;

  state_e                        state_q, state_d;
  logic [6:0]                    full_q, full_d;
  logic [2:0]                    idx_q, idx_d;
  logic                          done_q, done_d;
  logic [FRAME_CNT_BITWIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]                  word_q [5];
  logic [IMG_COL_BITWIDTH-1:0]   x1_q;
  logic [IMG_ROW_BITWIDTH-1:0]   y1_q;

  logic [6:0]   in_valid, in_ready, xfer, full_next;
  logic [W-1:0] in_word [5];
  logic [SW-1:0] off_x, off_y;

  // Channel order in the 7-bit vectors: 0..4 result words, 5 X1, 6 Y1.
  assign in_valid = {crop_Y1_TVALID, crop_X1_TVALID, cnn_output_4_TVALID,
                     cnn_output_3_TVALID, cnn_output_2_TVALID,
                     cnn_output_1_TVALID, cnn_output_0_TVALID};
  assign in_ready = ap_rst ? '0 : ~full_q;
  assign xfer      = in_valid & in_ready;
  assign full_next = full_q | xfer;

  assign cnn_output_0_TREADY = in_ready[0];
  assign cnn_output_1_TREADY = in_ready[1];
  assign cnn_output_2_TREADY = in_ready[2];
  assign cnn_output_3_TREADY = in_ready[3];
  assign cnn_output_4_TREADY = in_ready[4];
  assign crop_X1_TREADY      = in_ready[5];
  assign crop_Y1_TREADY      = in_ready[6];

  assign in_word[0] = cnn_output_0_TDATA;
  assign in_word[1] = cnn_output_1_TDATA;
  assign in_word[2] = cnn_output_2_TDATA;
  assign in_word[3] = cnn_output_3_TDATA;
  assign in_word[4] = cnn_output_4_TDATA;

  // Crop origins are unsigned: zero-extend before aligning to the fixed point.
  assign off_x = SW'(x1_q) << FP_FRAC;
  assign off_y = SW'(y1_q) << FP_FRAC;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] mu,
                                           input logic [SW-1:0] off);
    logic signed [SW-1:0] sum;
    sum = $signed({{2{mu[W-1]}}, mu}) + $signed(off);
    if (sum > SAT_MAX)      return SAT_MAX[W-1:0];
    else if (sum < SAT_MIN) return SAT_MIN[W-1:0];
    else                    return sum[W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    full_d  = full_next;
    idx_d   = idx_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_COLLECT: begin
        idx_d = '0;
        // Include this cycle's transfers so COMPUTE follows the last one directly.
        if (&full_next) state_d = S_COMPUTE;
      end
      S_COMPUTE: state_d = S_EMIT;
      S_EMIT: begin
        if (result_TREADY) begin
          if (idx_q == 3'd4) begin
            full_d  = '0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            idx_d   = '0;
            state_d = S_COLLECT;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_COLLECT;
      full_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      for (int unsigned k = 0; k < 5; k++) word_q[k] <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      for (int unsigned k = 0; k < 5; k++) begin
        if (xfer[k]) word_q[k] <= in_word[k];
      end
      if (xfer[5]) x1_q <= crop_X1_TDATA;
      if (xfer[6]) y1_q <= crop_Y1_TDATA;
      // mu_x/mu_y holding registers are rewritten in place with the
      // absolute coordinates; no input can arrive while all flags are full.
      if (state_q == S_COMPUTE) begin
        word_q[1] <= sat_add(word_q[1], off_x);
        word_q[2] <= sat_add(word_q[2], off_y);
      end
    end
  end

  assign result_TVALID = (state_q == S_EMIT);
  assign result_TDATA  = (state_q == S_EMIT) ? word_q[idx_q] : '0;
  assign result_TLAST  = (state_q == S_EMIT) && (idx_q == 3'd4);
  assign frame_done    = done_q;
  assign frame_count   = cnt_q;

endmodule
